// File: rtl/hilo_div_unit.sv
// HI/LO register pair with MULT/MTHI/MTLO writes and a 32-step sequential restoring divider.
// Latency: writes take effect next edge; DIV/DIVU busy 32 cycles, results on the 32nd edge with a div_done pulse.
// Backpressure: div_busy stalls the pipeline; requests while busy are ignored. HILO_BYPASS_EN forwards IDLE writes to hi_out/lo_out.
module hilo_div_unit #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cancel,
    input  logic        mult_we,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_busy,
    output logic        div_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [31:0] hi_q, lo_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        q_neg_q, r_neg_q, dz_q;
    logic [5:0]  cnt_q;
    logic        done_q;

    logic        start, idle_wr, last;
    logic        hi_we, lo_we;
    logic [31:0] hi_wd, lo_wd;
    logic [31:0] abs1, abs2;
    logic [32:0] shifted, trial;
    logic [31:0] rem_step, quo_step, rem_fix, quo_fix;

    assign start   = (state == IDLE) && div_start && !cancel;
    assign idle_wr = (state == IDLE) && !cancel && !div_start;
    assign last    = (state == RUN) && !cancel && (cnt_q == 6'(DIV_ITER - 1));

    assign abs1 = (div_signed && div_src1[31]) ? -div_src1 : div_src1;
    assign abs2 = (div_signed && div_src2[31]) ? -div_src2 : div_src2;

    // Partial remainder never exceeds the divisor, so 33 bits hold the shifted value.
    assign shifted  = {rem_q, quo_q[31]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign rem_step = trial[32] ? shifted[31:0] : trial[31:0];
    assign quo_step = {quo_q[30:0], ~trial[32]};

    // Divide-by-zero: raw quotient is all ones; the remainder fix restores the original dividend.
    assign quo_fix = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_step : quo_step);
    assign rem_fix = r_neg_q ? -rem_step : rem_step;

    always_comb begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_wd = mt_data;
        lo_wd = mt_data;
        if (idle_wr) begin
            if (mult_we) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                hi_wd = mult_hi;
                lo_wd = mult_lo;
            end else begin
                hi_we = mthi_we;
                lo_we = mtlo_we;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cancel || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= last;
            if (start) begin
                rem_q   <= '0;
                quo_q   <= abs1;
                dvs_q   <= abs2;
                q_neg_q <= div_signed & (div_src1[31] ^ div_src2[31]);
                r_neg_q <= div_signed & div_src1[31];
                dz_q    <= (div_src2 == 32'd0);
                cnt_q   <= '0;
            end else if (state == RUN && !cancel) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt_q <= cnt_q + 6'd1;
            end
            if (last) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else begin
                if (hi_we) hi_q <= hi_wd;
                if (lo_we) lo_q <= lo_wd;
            end
        end
    end

    assign div_busy = (state == RUN);
    assign div_done = done_q;

`ifdef HILO_BYPASS_EN
    assign hi_out = hi_we ? hi_wd : hi_q;
    assign lo_out = lo_we ? lo_wd : lo_q;
`else
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed table, hand sequences, random divisions vs arithmetic model.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cancel = 1'b0;
    logic        mult_we = 1'b0;
    logic [31:0] mult_hi = '0;
    logic [31:0] mult_lo = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] div_src1 = '0;
    logic [31:0] div_src2 = '0;
    logic [31:0] hi_out, lo_out;
    logic        div_busy, div_done;

    int tests = 0;
    int fails = 0;

    hilo_div_unit dut (
        .clk(clk), .resetn(resetn), .cancel(cancel),
        .mult_we(mult_we), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .div_start(div_start), .div_signed(div_signed),
        .div_src1(div_src1), .div_src2(div_src2),
        .hi_out(hi_out), .lo_out(lo_out),
        .div_busy(div_busy), .div_done(div_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // MIPS DIV/DIVU semantics computed with plain 64-bit arithmetic.
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the div_done edge so the next call is back-to-back.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input bit timing, input string tag);
        int cycles = 0;
        int busy_cnt = 0;
        div_start = 1'b1; div_signed = sgn; div_src1 = a; div_src2 = b;
        step();
        div_start = 1'b0;
        while (!div_done && cycles < 40) begin
            if (div_busy) busy_cnt++;
            step();
            cycles++;
        end
        if (!div_done) begin
            tests++; fails++;
            $display("FAIL %s timeout: no div_done after %0d cycles", tag, cycles);
        end else begin
            if (timing) begin
                check({tag, " done_cycle"}, 32'(cycles), 32'd32);
                check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd32);
                check({tag, " busy_in_done"}, {31'd0, div_busy}, 32'd0);
            end
            check({tag, " lo"}, lo_out, exp_lo);
            check({tag, " hi"}, hi_out, exp_hi);
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] rl, rh, ra, rb;
        logic        rs;
        bit          seen;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[4] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};

        #3;
        check("reset hi", hi_out, 32'd0);
        check("reset lo", lo_out, 32'd0);
        check("reset busy", {31'd0, div_busy}, 32'd0);
        check("reset done", {31'd0, div_done}, 32'd0);
        #10 resetn = 1'b1;
        step();

        // Directed table, issued back-to-back (each start lands in the previous done cycle).
        for (int i = 0; i < 8; i++)
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, 1'b1,
                   $sformatf("vec%0d", i));
        step();

        // mult_we beats mthi_we in the same cycle.
        mult_we = 1'b1; mult_hi = 32'hAAAA_0000; mult_lo = 32'h0000_BBBB;
        mthi_we = 1'b1; mt_data = 32'h5;
        step();
        mult_we = 1'b0; mthi_we = 1'b0;
        check("mult_prio hi", hi_out, 32'hAAAA_0000);
        check("mult_prio lo", lo_out, 32'h0000_BBBB);

        // mult_we while busy is ignored.
        div_start = 1'b1; div_signed = 1'b0; div_src1 = 32'd100; div_src2 = 32'd7;
        step();
        div_start = 1'b0;
        mult_we = 1'b1; mult_hi = 32'h1; mult_lo = 32'h2;
        step();
        mult_we = 1'b0;
        check("busy_mult hi", hi_out, 32'hAAAA_0000);
        check("busy_mult lo", lo_out, 32'h0000_BBBB);
        for (int i = 0; i < 40 && !div_done; i++) step();
        check("busy_mult div lo", lo_out, 32'd14);
        check("busy_mult div hi", hi_out, 32'd2);
        step();

        // Preload, then cancel on busy cycle 10.
        mthi_we = 1'b1; mt_data = 32'h11;
        step();
        mthi_we = 1'b0; mtlo_we = 1'b1; mt_data = 32'h22;
        step();
        mtlo_we = 1'b0;
        div_start = 1'b1; div_signed = 1'b0; div_src1 = 32'd100; div_src2 = 32'd7;
        step();
        div_start = 1'b0;
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel busy", {31'd0, div_busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (div_done) seen = 1'b1;
            step();
        end
        check("cancel no_done", {31'd0, seen}, 32'd0);
        check("cancel hi", hi_out, 32'h11);
        check("cancel lo", lo_out, 32'h22);

        // cancel in IDLE blocks a write.
        cancel = 1'b1; mthi_we = 1'b1; mt_data = 32'h99;
        step();
        cancel = 1'b0; mthi_we = 1'b0;
        check("idle_cancel hi", hi_out, 32'h11);

        // Bypass: LO is 0x22 beforehand.
        mtlo_we = 1'b1; mt_data = 32'h1234;
        #1;
`ifdef HILO_BYPASS_EN
        check("bypass same_cycle", lo_out, 32'h1234);
`else
        check("bypass same_cycle", lo_out, 32'h22);
`endif
        @(posedge clk); #1;
        mtlo_we = 1'b0;
        check("bypass next_cycle", lo_out, 32'h1234);

        // Reset in the middle of a division.
        div_start = 1'b1; div_signed = 1'b1; div_src1 = 32'd1000; div_src2 = 32'd3;
        step();
        div_start = 1'b0;
        repeat (5) step();
        #2 resetn = 1'b0;
        #1;
        check("midreset hi", hi_out, 32'd0);
        check("midreset lo", lo_out, 32'd0);
        check("midreset busy", {31'd0, div_busy}, 32'd0);
        #10 resetn = 1'b1;
        step();

        // Random divisions against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: rb = $urandom;
            endcase
            if (i == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
            ref_div(rs, ra, rb, rl, rh);
            do_div(rs, ra, rb, rl, rh, 1'b0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
